// File: rtl/uart_rx_engine.sv
// uart_rx_engine: UART serial receiver. Synchronises RX, detects the start
// bit, times bits from a 16-entry baud table and assembles 7/8-bit characters
// with optional parity. Latency: outputs are valid the cycle after DONE.
// Ports: clk/reset (sync, active-high); RX serial in; baud_value/EIGHT/PEN/OHEL
//   frame config, latched at start detection; READ consumer strobe;
//   DATA/RXRDY/PERR/FERR/OVF received character and status;
//   BTU mid-bit sample pulse; DONE frame-complete pulse.
module uart_rx_engine #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RX,
  input  logic [3:0] baud_value,
  input  logic       EIGHT,
  input  logic       PEN,
  input  logic       OHEL,
  input  logic       READ,
  output logic [7:0] DATA,
  output logic       RXRDY,
  output logic       PERR,
  output logic       FERR,
  output logic       OVF,
  output logic       BTU,
  output logic       DONE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  logic [3:0]  baud_q;
  logic        eight_q;
  logic        pen_q;
  logic        ohel_q;

  logic [18:0] cnt;
  logic [3:0]  bit_cnt;
  logic [9:0]  shreg;

  logic [18:0] k;
  logic [18:0] half;
  logic [3:0]  nbits;

  logic [9:0]  aligned;
  logic [7:0]  data_f;
  logic        par_f;
  logic        stop_f;
  logic        perr_f;

  function automatic logic [18:0] baud_k(input logic [3:0] sel);
    case (sel)
      4'd0:    baud_k = 19'd333333;
      4'd1:    baud_k = 19'd83333;
      4'd2:    baud_k = 19'd41667;
      4'd3:    baud_k = 19'd20833;
      4'd4:    baud_k = 19'd10417;
      4'd5:    baud_k = 19'd5208;
      4'd6:    baud_k = 19'd2604;
      4'd7:    baud_k = 19'd1736;
      4'd8:    baud_k = 19'd868;
      4'd9:    baud_k = 19'd434;
      4'd10:   baud_k = 19'd217;
      default: baud_k = 19'd109;
    endcase
  endfunction

  assign rx_s  = sync_q[SYNC_STAGES-1];
  assign k     = baud_k(baud_q);
  assign half  = {1'b0, k[18:1]};
  // data bits + optional parity + one stop bit
  assign nbits = 4'd8 + {3'b000, eight_q} + {3'b000, pen_q};

  // The frame occupies the top nbits of the right-shifting register; align it
  // to bit 0 so data, parity and stop sit at fixed offsets.
  assign aligned = shreg >> (4'd10 - nbits);
  assign data_f  = eight_q ? aligned[7:0] : {1'b0, aligned[6:0]};
  assign par_f   = eight_q ? aligned[8] : aligned[7];
  assign stop_f  = aligned[nbits - 4'd1];
  assign perr_f  = pen_q & ((^data_f ^ par_f) != ohel_q);

  // Input synchroniser; stages idle high so reset does not look like a start.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    BTU       = 1'b0;
    DONE      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) state_nxt = S_START;
      end
      S_START: begin
        if (cnt == half) begin
          if (!rx_s) begin
            BTU       = 1'b1;
            state_nxt = S_DATA;
          end else begin
            state_nxt = S_IDLE;     // false start: glitch shorter than half a bit
          end
        end
      end
      S_DATA: begin
        if (cnt == k - 19'd1) begin
          BTU = 1'b1;
          if (bit_cnt + 4'd1 == nbits) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        DONE      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit timing, frame config latch and shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      baud_q  <= '0;
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
      ohel_q  <= 1'b0;
    end else begin
      if (state == S_IDLE || BTU || state_nxt != state) cnt <= '0;
      else                                              cnt <= cnt + 19'd1;

      if (state == S_IDLE) begin
        bit_cnt <= '0;
        if (!rx_s) begin
          baud_q  <= baud_value;
          eight_q <= EIGHT;
          pen_q   <= PEN;
          ohel_q  <= OHEL;
        end
      end else if (state == S_DATA && BTU) begin
        shreg   <= {rx_s, shreg[9:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  // Consumer-facing status; a completing frame takes priority over READ.
  always_ff @(posedge clk) begin
    if (reset) begin
      DATA  <= 8'h00;
      RXRDY <= 1'b0;
      PERR  <= 1'b0;
      FERR  <= 1'b0;
      OVF   <= 1'b0;
    end else if (DONE) begin
      DATA  <= data_f;
      PERR  <= perr_f;
      FERR  <= ~stop_f;
      OVF   <= RXRDY & ~READ;
      RXRDY <= 1'b1;
    end else if (READ) begin
      RXRDY <= 1'b0;
      PERR  <= 1'b0;
      FERR  <= 1'b0;
      OVF   <= 1'b0;
    end
  end

endmodule
